vga_capture: RTL

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vga_capture.sv
// Captures pixels from a VGA output bus by oversampling it with CLOCK_50 and
// emits x/y/colour plot strobes plus frame-level lock and error status.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic [23:0] colour,
  output logic        plot,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        locked,
  output logic        sync_error
);

  typedef enum logic [1:0] {SEEK, WAIT_ACTIVE, ACTIVE} state_t;

  localparam logic [9:0] H_LEN = 10'(H_ACTIVE);
  localparam logic [8:0] V_LEN = 9'(V_ACTIVE);
  localparam logic [9:0] X_MAX = '1;
  localparam logic [8:0] Y_MAX = '1;

  // Sample stage
  logic        vclk_s, vclk_q, vs_s, blank_s;
  logic        hs_sample_unused;
  logic [23:0] rgb_s;

  // Capture state
  state_t      state, state_n;
  logic [9:0]  xcnt, xcnt_n;
  logic [8:0]  ycnt, ycnt_n;
  logic        frame_err, frame_err_n;
  logic        vs_prev, vs_prev_n, blank_prev, blank_prev_n;

  // Next values of registered outputs
  logic [9:0]  x_n;
  logic [8:0]  y_n;
  logic [23:0] colour_n;
  logic        plot_n, frame_done_n, locked_n, sync_error_n;
  logic [15:0] frame_count_n;

  logic pixel_tick, vs_fall, blank_fall;

  // HS is sampled alongside the rest of the bus; line timing comes from BLANK_N.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      vclk_s           <= 1'b0;
      vclk_q           <= 1'b0;
      vs_s             <= 1'b0;
      blank_s          <= 1'b0;
      hs_sample_unused <= 1'b0;
      rgb_s            <= '0;
    end else begin
      vclk_s           <= VGA_CLK;
      vclk_q           <= vclk_s;
      vs_s             <= VGA_VS;
      blank_s          <= VGA_BLANK_N;
      hs_sample_unused <= VGA_HS;
      rgb_s            <= {VGA_R, VGA_G, VGA_B};
    end
  end

  assign pixel_tick = vclk_s & ~vclk_q;
  assign vs_fall    = pixel_tick & ~vs_s & vs_prev;
  assign blank_fall = pixel_tick & ~blank_s & blank_prev;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state       <= SEEK;
      xcnt        <= '0;
      ycnt        <= '0;
      frame_err   <= 1'b0;
      vs_prev     <= 1'b0;
      blank_prev  <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      locked      <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      state       <= state_n;
      xcnt        <= xcnt_n;
      ycnt        <= ycnt_n;
      frame_err   <= frame_err_n;
      vs_prev     <= vs_prev_n;
      blank_prev  <= blank_prev_n;
      x           <= x_n;
      y           <= y_n;
      colour      <= colour_n;
      plot        <= plot_n;
      frame_done  <= frame_done_n;
      frame_count <= frame_count_n;
      locked      <= locked_n;
      sync_error  <= sync_error_n;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_n       = state;
    xcnt_n        = xcnt;
    ycnt_n        = ycnt;
    frame_err_n   = frame_err;
    vs_prev_n     = vs_prev;
    blank_prev_n  = blank_prev;
    x_n           = x;
    y_n           = y;
    colour_n      = colour;
    plot_n        = 1'b0;
    frame_done_n  = 1'b0;
    frame_count_n = frame_count;
    locked_n      = locked;
    sync_error_n  = sync_error;

    if (pixel_tick) begin
      vs_prev_n    = vs_s;
      blank_prev_n = blank_s;

      if (vs_fall) begin
        // Judge the frame that just ended before the counters are cleared.
        if (state != SEEK) begin
          if (ycnt == V_LEN) begin
            if (!frame_err) begin
              frame_done_n  = 1'b1;
              frame_count_n = frame_count + 16'd1;
            end
          end else begin
            sync_error_n = 1'b1;
          end
        end
        state_n     = WAIT_ACTIVE;
        xcnt_n      = '0;
        ycnt_n      = '0;
        frame_err_n = 1'b0;
        locked_n    = 1'b1;
      end else begin
        case (state)
          SEEK: ;
          WAIT_ACTIVE, ACTIVE: begin
            if (state == ACTIVE && blank_fall) begin
              if (xcnt != H_LEN) begin
                sync_error_n = 1'b1;
                frame_err_n  = 1'b1;
              end
              xcnt_n = '0;
              if (ycnt != Y_MAX) ycnt_n = ycnt + 9'd1;
            end else if (blank_s) begin
              // Active video beyond the last expected line means we lost sync.
              if (ycnt >= V_LEN) begin
                sync_error_n = 1'b1;
                state_n      = SEEK;
                locked_n     = 1'b0;
              end else begin
                plot_n   = 1'b1;
                x_n      = xcnt;
                y_n      = ycnt;
                colour_n = rgb_s;
                state_n  = ACTIVE;
                if (xcnt != X_MAX) xcnt_n = xcnt + 10'd1;
              end
            end
          end
          default: state_n = SEEK;
        endcase
      end
    end
  end

endmodule
